// File: rtl/tmds_link_ctrl.sv
// TMDS link bring-up controller: waits for a stable PLL lock, pulses the serializer
// reset, sends a run of idle control symbols, then passes encoded pixel data.
module tmds_link_ctrl #(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned SERDES_RST_CYCLES  = 16,
  parameter int unsigned IDLE_CYCLES        = 64,
  parameter logic [9:0]  IDLE_WORD          = 10'b1101010100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       enable,
  input  logic [9:0] data_in,
  input  logic       data_valid,
  output logic       serdes_rst,
  output logic [9:0] data_out,
  output logic       link_up,
  output logic       underrun,
  output logic [1:0] state
);

  // state      | meaning
  // WAIT_LOCK  | serializer held in reset, counting continuous lock+enable cycles
  // SERDES_RST | serializer reset pulse after lock is stable
  // IDLE       | serializer running, idle control symbols only
  // ACTIVE     | pixel data passes through, link_up high

  localparam int unsigned MAX_A = (LOCK_STABLE_CYCLES > SERDES_RST_CYCLES) ?
                                  LOCK_STABLE_CYCLES : SERDES_RST_CYCLES;
  localparam int unsigned MAX_P = (MAX_A > IDLE_CYCLES) ? MAX_A : IDLE_CYCLES;
  localparam int unsigned CW    = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] SRST_LAST = CW'(SERDES_RST_CYCLES - 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK  = 2'd0,
    ST_SERDES_RST = 2'd1,
    ST_IDLE       = 2'd2,
    ST_ACTIVE     = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lock_meta_q, lock_meta_d;
  logic          lock_s_q, lock_s_d;
  logic          serdes_rst_q, serdes_rst_d;
  logic [9:0]    data_out_q, data_out_d;
  logic          link_up_q, link_up_d;
  logic          underrun_q, underrun_d;
  logic          link_ok;

  always_comb begin
    lock_meta_d = pll_locked;
    lock_s_d    = lock_meta_q;
    link_ok     = lock_s_q & enable;
    state_d     = state_q;
    cnt_d       = cnt_q;

    // Losing lock or enable outside WAIT_LOCK overrides any pending count expiry.
    if ((state_q != ST_WAIT_LOCK) && !link_ok) begin
      state_d = ST_WAIT_LOCK;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_WAIT_LOCK: begin
          if (!link_ok) begin
            cnt_d = '0;
          end else if (cnt_q == LOCK_LAST) begin
            state_d = ST_SERDES_RST;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_SERDES_RST: begin
          if (cnt_q == SRST_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_IDLE: begin
          if (cnt_q == IDLE_LAST) begin
            state_d = ST_ACTIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_ACTIVE: begin
          state_d = ST_ACTIVE;
        end
        default: begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      endcase
    end

    serdes_rst_d = (state_d == ST_WAIT_LOCK) || (state_d == ST_SERDES_RST);
    link_up_d    = (state_d == ST_ACTIVE);
    data_out_d   = ((state_q == ST_ACTIVE) && data_valid) ? data_in : IDLE_WORD;
    underrun_d   = (state_q == ST_ACTIVE) && !data_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_WAIT_LOCK;
      cnt_q        <= '0;
      lock_meta_q  <= 1'b0;
      lock_s_q     <= 1'b0;
      serdes_rst_q <= 1'b1;
      data_out_q   <= IDLE_WORD;
      link_up_q    <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lock_meta_q  <= lock_meta_d;
      lock_s_q     <= lock_s_d;
      serdes_rst_q <= serdes_rst_d;
      data_out_q   <= data_out_d;
      link_up_q    <= link_up_d;
      underrun_q   <= underrun_d;
    end
  end

  assign serdes_rst = serdes_rst_q;
  assign data_out   = data_out_q;
  assign link_up    = link_up_q;
  assign underrun   = underrun_q;
  assign state      = state_q;

endmodule

// File: tb/tb_tmds_link_ctrl.sv
// Bench for tmds_link_ctrl: directed bring-up/abort/reset scenarios plus random
// lock/enable/data traffic, all compared against a cycle reference model.
module tb_tmds_link_ctrl;

  localparam int         LOCK  = 8;
  localparam int         SRST  = 4;
  localparam int         IDLEC = 4;
  localparam logic [9:0] IW    = 10'h354;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pll_locked = 1'b0;
  logic       enable = 1'b0;
  logic [9:0] data_in = '0;
  logic       data_valid = 1'b0;
  logic       serdes_rst;
  logic [9:0] data_out;
  logic       link_up;
  logic       underrun;
  logic [1:0] state;

  always #5 clk = ~clk;

  tmds_link_ctrl #(
    .LOCK_STABLE_CYCLES(LOCK),
    .SERDES_RST_CYCLES (SRST),
    .IDLE_CYCLES       (IDLEC),
    .IDLE_WORD         (IW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .enable    (enable),
    .data_in   (data_in),
    .data_valid(data_valid),
    .serdes_rst(serdes_rst),
    .data_out  (data_out),
    .link_up   (link_up),
    .underrun  (underrun),
    .state     (state)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: phase number, cycles spent in the phase, and a 2-deep lock history.
  int         m_phase;
  int         m_run;
  bit         m_hist[2];
  logic [9:0] m_dout;
  bit         m_ur;

  task automatic model_reset();
    m_phase   = 0;
    m_run     = 0;
    m_hist[0] = 1'b0;
    m_hist[1] = 1'b0;
    m_dout    = IW;
    m_ur      = 1'b0;
  endtask

  task automatic model_edge(input bit pll, input bit en, input bit dv, input logic [9:0] din);
    bit ok;
    ok     = m_hist[1] && en;
    m_dout = (m_phase == 3 && dv) ? din : IW;
    m_ur   = (m_phase == 3) && !dv;
    if (m_phase != 0 && !ok) begin
      m_phase = 0;
      m_run   = 0;
    end else if (m_phase == 0) begin
      m_run = ok ? m_run + 1 : 0;
      if (m_run == LOCK) begin
        m_phase = 1;
        m_run   = 0;
      end
    end else if (m_phase == 1 || m_phase == 2) begin
      m_run = m_run + 1;
      if (m_run == ((m_phase == 1) ? SRST : IDLEC)) begin
        m_phase = m_phase + 1;
        m_run   = 0;
      end
    end
    m_hist[1] = m_hist[0];
    m_hist[0] = pll;
  endtask

  task automatic check_outs();
    chk("state", {30'b0, state}, m_phase);
    chk("data_out", {22'b0, data_out}, {22'b0, m_dout});
    chk("serdes_rst", {31'b0, serdes_rst}, {31'b0, (m_phase <= 1)});
    chk("link_up", {31'b0, link_up}, {31'b0, (m_phase == 3)});
    chk("underrun", {31'b0, underrun}, {31'b0, m_ur});
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit pll, input bit en, input bit dv, input logic [9:0] din);
    pll_locked = pll;
    enable     = en;
    data_valid = dv;
    data_in    = din;
    @(posedge clk);
    model_edge(pll, en, dv, din);
    #1;
    check_outs();
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".state"}, {30'b0, state}, 32'd0);
    chk({tag, ".serdes_rst"}, {31'b0, serdes_rst}, 32'd1);
    chk({tag, ".data_out"}, {22'b0, data_out}, {22'b0, IW});
    chk({tag, ".link_up"}, {31'b0, link_up}, 32'd0);
    chk({tag, ".underrun"}, {31'b0, underrun}, 32'd0);
  endtask

  task automatic run_to_link(input int budget, output int n);
    n = 0;
    while (!link_up && n < budget) begin
      step(1'b1, 1'b1, 1'($urandom), 10'($urandom));
      n++;
    end
  endtask

  logic [9:0] words[3];
  int n, sr, idl;
  bit p, e;

  initial begin
    words[0] = 10'h2AB;
    words[1] = 10'h155;
    words[2] = 10'h3FF;
    pll_locked = 1'b1;
    enable     = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    check_reset_vals("reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Bring-up from reset with lock and enable already high.
    n = 0; sr = 0; idl = 0;
    while (!link_up && n < 40) begin
      step(1'b1, 1'b1, 1'($urandom), 10'($urandom));
      n++;
      if (serdes_rst) sr++;
      if (!serdes_rst && !link_up && data_out == IW) idl++;
    end
    chk("bringup_lat", n, 2 + LOCK + SRST + IDLEC);
    chk("bringup_srst_cycles", sr, 2 + LOCK + SRST - 1);
    chk("bringup_idle_cycles", idl, IDLEC);

    foreach (words[i]) begin
      step(1'b1, 1'b1, 1'b1, words[i]);
      chk("pass_data", {22'b0, data_out}, {22'b0, words[i]});
      chk("pass_underrun", {31'b0, underrun}, 32'd0);
    end

    step(1'b1, 1'b1, 1'b0, 10'h0AA);
    chk("ur_pulse", {31'b0, underrun}, 32'd1);
    chk("ur_data", {22'b0, data_out}, {22'b0, IW});
    chk("ur_link", {31'b0, link_up}, 32'd1);
    step(1'b1, 1'b1, 1'b1, 10'h0AA);
    chk("ur_one_cycle", {31'b0, underrun}, 32'd0);

    repeat (40) step(1'b1, 1'b1, 1'($urandom), 10'($urandom));

    // Abort via enable, then full re-bring-up with lock already synchronized.
    step(1'b1, 1'b0, 1'b1, 10'h123);
    chk("abort_state", {30'b0, state}, 32'd0);
    chk("abort_srst", {31'b0, serdes_rst}, 32'd1);
    chk("abort_link", {31'b0, link_up}, 32'd0);
    run_to_link(40, n);
    chk("rebring_lat", n, LOCK + SRST + IDLEC);

    // One-cycle lock glitch while the WAIT_LOCK count sits at 5.
    step(1'b1, 1'b0, 1'b0, 10'h0);
    repeat (5) step(1'b1, 1'b1, 1'b0, 10'h0);
    step(1'b0, 1'b1, 1'b0, 10'h0);
    n = 0;
    while (state != 2'd1 && n < 30) begin
      step(1'b1, 1'b1, 1'b0, 10'h0);
      n++;
    end
    chk("glitch_lat", n, 2 + LOCK);
    run_to_link(30, n);

    // Random lock/enable disturbances with random traffic.
    for (int k = 0; k < 400; k++) begin
      p = (($urandom % 64) != 0);
      e = (($urandom % 64) != 0);
      step(p, e, 1'($urandom), 10'($urandom));
    end

    run_to_link(60, n);
    chk("reach_active", {31'b0, link_up}, 32'd1);
    step(1'b1, 1'b1, 1'b1, 10'h2AB);

    // Reset pulse between clock edges while ACTIVE.
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    model_reset();
    #1 rst_n = 1'b1;
    run_to_link(40, n);
    chk("rst_rebring_lat", n, 2 + LOCK + SRST + IDLEC);
    repeat (20) step(1'b1, 1'b1, 1'($urandom), 10'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
